alu_result_sink: RTL and testbench
==================================

# alu_result_sink

Consumer side of the ALU's 64-bit result port `C`. It accepts one result per valid/ready handshake and tags it with its 5-bit opcode. It updates the architectural HI/LO registers for multiply/divide and serialises the result onto the 32-bit datapath bus as one beat (low word only) or two beats (low word, then high word). It sits between the ALU output and the Z/bus writeback path, and also flags sign-extension inconsistencies on add/sub results.

## Interface

Parameters:
- `CNT_W`, default 8: width of the accepted-result counter.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock
- `clear`  in  1  asynchronous, active-low reset
- `c_in`  in  64  ALU result `C`
- `opcode`  in  5  opcode of the operation that produced `c_in`
- `c_valid`  in  1  `c_in`/`opcode` valid
- `c_ready`  out  1  sink can accept a result
- `bus_data`  out  32  word driven to the datapath bus
- `bus_valid`  out  1  `bus_data` valid
- `bus_hi`  out  1  current beat is the high word
- `bus_ready`  in  1  bus consumer accepts the beat
- `hi_reg`  out  32  HI register
- `lo_reg`  out  32  LO register
- `ext_err`  out  1  sticky add/sub sign-extension error
- `result_count`  out  `CNT_W`  results accepted; wraps modulo 2^`CNT_W`

## Operation

Opcode encodings: add=00011, sub=00100, mul=10000, div=01111, nop=11010. Every other opcode is "single-beat other".

State machine with states IDLE, LO_BEAT and HI_BEAT:
- **c_ready.** `c_ready` = (state==IDLE) and `clear` high. A result is accepted only when `c_valid && c_ready` at a rising edge.
- **Capture (all non-nop opcodes).** On accept, latch `c_in` into internal zlo/zhi and latch the multi-beat flag (mul or div). Increment `result_count`.
- **mul/div accept.** Also load `hi_reg<=c_in[63:32]` and `lo_reg<=c_in[31:0]` on the same edge. Next state is LO_BEAT.
- **nop accept.** Increment `result_count` only. No capture, no HI/LO change, no beat. State stays IDLE.
- **add/sub accept.** If `c_in[63:32] != {32{c_in[31]}}`, set `ext_err`. It stays set until reset. Next state is LO_BEAT.
- **Other opcodes.** Next state is LO_BEAT. `ext_err` is not checked.
- **LO_BEAT.** Drive `bus_valid=1`, `bus_data=zlo`, `bus_hi=0`. On `bus_ready`, go to HI_BEAT if the multi-beat flag is set, else go to IDLE.
- **HI_BEAT.** Drive `bus_valid=1`, `bus_data=zhi`, `bus_hi=1`. On `bus_ready`, go to IDLE.
- **Stable while stalled.** `bus_data`, `bus_hi` and `bus_valid` must not change while `bus_valid && !bus_ready`.
- **Outside beat states.** `bus_valid=0`, `bus_hi=0`, `bus_data=0`.
- **Upstream rules.** `c_valid` while not ready is ignored, with no capture. Upstream must hold `c_in` until accepted.

## Timing

- Reset (`clear` low) forces the following immediately, regardless of clock:
  - state=IDLE
  - `c_ready=0`, `bus_valid=0`, `bus_hi=0`
  - `bus_data=0`, `hi_reg=0`, `lo_reg=0`
  - `ext_err=0`, `result_count=0`
- After reset deasserts, `c_ready=1` in the same cycle.
- Reset asserted mid-transfer aborts the result. No partial beat remains after release.
- Accept at edge N gives `bus_valid=1` after edge N.
- With `bus_ready` tied high:
  - single-beat: low beat is accepted at N+1, state is IDLE after N+1, and `c_ready=1` in cycle N+1→N+2. Throughput is 1 result per 2 cycles.
  - two-beat: low beat at N+1, high beat at N+2. Throughput is 1 result per 3 cycles.
- nop: `c_ready` stays 1, so back-to-back nops are accepted every cycle.
- `hi_reg`/`lo_reg` update at the accept edge, before the bus beats complete.
- `result_count` wraps from 2^`CNT_W`-1 to 0 with no flag.
- `ext_err` sets at the accepting edge of the offending result.

## Test plan

- **Reset.** Assert `clear`=0 mid-HI_BEAT with `hi_reg`=0x1234 → all outputs go to 0 asynchronously. After release, `c_ready=1` and `bus_valid=0`.
- **add, bus_ready=1.** Accept add with `c_in`=0xFFFFFFFF_FFFFFFFE → one beat `bus_data`=0xFFFFFFFE, `bus_hi=0`. `ext_err`=0, HI/LO unchanged, `result_count`=1.
- **mul, bus_ready stalled.** Accept mul with `c_in`=0x00000002_80000000, `bus_ready`=0 for 3 cycles → `hi_reg`=0x00000002 and `lo_reg`=0x80000000 right after accept. `bus_data`=0x80000000 is held stable 3 cycles, then 0x00000002 with `bus_hi=1`.
- **sub sign-extension error.** Accept sub with `c_in`=0x00000000_80000000 → `ext_err`=1 and it stays 1 through subsequent clean results until reset.
- **Stream, bus_ready=1.** Send nop, nop, div(0x00000003_00000007), add(0x5) with `c_valid` held → nops accepted on consecutive cycles. Beats are 0x7, 0x3(hi), 0x5. `c_ready` is low during beats, and `result_count`=4.
- **Counter wrap.** With `CNT_W`=8, send 256 nops → `result_count` wraps to 0. A result presented while `c_ready=0` is not counted.

Source files
------------

// File: rtl/alu_result_sink.sv
// Consumer of the ALU 64-bit result port: captures results, maintains HI/LO,
// and serialises each result onto the 32-bit datapath bus as one or two beats.
module alu_result_sink #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [63:0]      c_in,
    input  logic [4:0]       opcode,
    input  logic             c_valid,
    output logic             c_ready,
    output logic [31:0]      bus_data,
    output logic             bus_valid,
    output logic             bus_hi,
    input  logic             bus_ready,
    output logic [31:0]      hi_reg,
    output logic [31:0]      lo_reg,
    output logic             ext_err,
    output logic [CNT_W-1:0] result_count
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NOP = 5'b11010;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LO_BEAT = 2'b01,
        S_HI_BEAT = 2'b10
    } state_t;

    function automatic logic is_multi(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_addsub(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // An add/sub result is consistent only if the upper word replicates bit 31.
    function automatic logic sext_bad(input logic [63:0] c);
        return c[63:32] != {32{c[31]}};
    endfunction

    state_t           state_r;
    logic             idle_r;
    logic [31:0]      zhi_r;
    logic             multi_r;
    logic [31:0]      bus_data_r;
    logic             bus_valid_r;
    logic             bus_hi_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             ext_err_r;
    logic [CNT_W-1:0] count_r;
    logic             accept_s;

    // Ready is gated by the reset input so it drops the moment clear falls.
    always_comb begin
        c_ready  = idle_r & clear;
        accept_s = c_valid & c_ready;
    end

    // Result capture, HI/LO update and beat sequencing.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r     <= S_IDLE;
            idle_r      <= 1'b1;
            zhi_r       <= 32'h0000_0000;
            multi_r     <= 1'b0;
            bus_data_r  <= 32'h0000_0000;
            bus_valid_r <= 1'b0;
            bus_hi_r    <= 1'b0;
            hi_r        <= 32'h0000_0000;
            lo_r        <= 32'h0000_0000;
            ext_err_r   <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        count_r <= count_r + CNT_W'(1);
                        // A nop is only counted; it never occupies the bus.
                        if (opcode != OP_NOP) begin
                            zhi_r       <= c_in[63:32];
                            multi_r     <= is_multi(opcode);
                            bus_data_r  <= c_in[31:0];
                            bus_valid_r <= 1'b1;
                            bus_hi_r    <= 1'b0;
                            idle_r      <= 1'b0;
                            state_r     <= S_LO_BEAT;
                            if (is_multi(opcode)) begin
                                hi_r <= c_in[63:32];
                                lo_r <= c_in[31:0];
                            end
                            if (is_addsub(opcode) && sext_bad(c_in)) begin
                                ext_err_r <= 1'b1;
                            end
                        end
                    end
                end
                S_LO_BEAT: begin
                    if (bus_ready) begin
                        if (multi_r) begin
                            bus_data_r <= zhi_r;
                            bus_hi_r   <= 1'b1;
                            state_r    <= S_HI_BEAT;
                        end else begin
                            bus_data_r  <= 32'h0000_0000;
                            bus_valid_r <= 1'b0;
                            bus_hi_r    <= 1'b0;
                            idle_r      <= 1'b1;
                            state_r     <= S_IDLE;
                        end
                    end
                end
                S_HI_BEAT: begin
                    if (bus_ready) begin
                        bus_data_r  <= 32'h0000_0000;
                        bus_valid_r <= 1'b0;
                        bus_hi_r    <= 1'b0;
                        idle_r      <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    bus_data_r  <= 32'h0000_0000;
                    bus_valid_r <= 1'b0;
                    bus_hi_r    <= 1'b0;
                    idle_r      <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_data     = bus_data_r;
    assign bus_valid    = bus_valid_r;
    assign bus_hi       = bus_hi_r;
    assign hi_reg       = hi_r;
    assign lo_reg       = lo_r;
    assign ext_err      = ext_err_r;
    assign result_count = count_r;

endmodule

// File: tb/tb_alu_result_sink.sv
// Self-checking bench for alu_result_sink: directed scenarios plus random traffic
// compared against a queue-of-expected-beats reference model.
module tb_alu_result_sink;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NOP = 5'b11010;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] c_in = 64'd0;
    logic [4:0]  opcode = 5'd0;
    logic        c_valid = 1'b0;
    logic        c_ready;
    logic [31:0] bus_data;
    logic        bus_valid;
    logic        bus_hi;
    logic        bus_ready = 1'b0;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        ext_err;
    logic [7:0]  result_count;

    alu_result_sink #(.CNT_W(8)) dut (
        .clock(clock), .clear(clear), .c_in(c_in), .opcode(opcode),
        .c_valid(c_valid), .c_ready(c_ready), .bus_data(bus_data),
        .bus_valid(bus_valid), .bus_hi(bus_hi), .bus_ready(bus_ready),
        .hi_reg(hi_reg), .lo_reg(lo_reg), .ext_err(ext_err),
        .result_count(result_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic        hi;
    } beat_t;

    // Reference model: pending bus beats plus architectural state.
    beat_t       q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_ext = 1'b0;
    logic [7:0]  m_cnt = 8'd0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_ext = 1'b0;
        m_cnt = 8'd0;
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [31:0] ed;
        logic        eh;
        ev = (q.size() != 0);
        ed = ev ? q[0].data : 32'd0;
        eh = ev ? q[0].hi : 1'b0;
        chk("c_ready", 64'(c_ready), 64'(!ev));
        chk("bus_valid", 64'(bus_valid), 64'(ev));
        chk("bus_data", 64'(bus_data), 64'(ed));
        chk("bus_hi", 64'(bus_hi), 64'(eh));
        chk("hi_reg", 64'(hi_reg), 64'(m_hi));
        chk("lo_reg", 64'(lo_reg), 64'(m_lo));
        chk("ext_err", 64'(ext_err), 64'(m_ext));
        chk("result_count", 64'(result_count), 64'(m_cnt));
    endtask

    // One clock: check at the falling edge, drive inputs, predict the rising edge.
    task automatic cycle(input logic v, input logic [4:0] op, input logic [63:0] c,
                         input logic br, output logic acc);
        @(negedge clock);
        check_outputs();
        c_valid = v;
        opcode = op;
        c_in = c;
        bus_ready = br;
        acc = 1'b0;
        if (q.size() != 0) begin
            if (br) void'(q.pop_front());
        end else if (v) begin
            acc = 1'b1;
            m_cnt = m_cnt + 8'd1;
            if (op != OP_NOP) begin
                q.push_back('{data: c[31:0], hi: 1'b0});
                if (op == OP_MUL || op == OP_DIV) begin
                    q.push_back('{data: c[63:32], hi: 1'b1});
                    m_hi = c[63:32];
                    m_lo = c[31:0];
                end
                if ((op == OP_ADD || op == OP_SUB) && ($signed(c) != 64'($signed(c[31:0]))))
                    m_ext = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] op, input logic [63:0] c, input logic br);
        logic a;
        cycle(v, op, c, br, a);
    endtask

    // Asynchronous reset between clock edges, then release at a falling edge.
    task automatic do_reset();
        @(posedge clock);
        #1;
        check_outputs();
        #1;
        clear = 1'b0;
        #1;
        chk("rst_c_ready", 64'(c_ready), 64'd0);
        chk("rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_bus_hi", 64'(bus_hi), 64'd0);
        chk("rst_bus_data", 64'(bus_data), 64'd0);
        chk("rst_hi_reg", 64'(hi_reg), 64'd0);
        chk("rst_lo_reg", 64'(lo_reg), 64'd0);
        chk("rst_ext_err", 64'(ext_err), 64'd0);
        chk("rst_count", 64'(result_count), 64'd0);
        model_reset();
        @(negedge clock);
        c_valid = 1'b0;
        bus_ready = 1'b0;
        clear = 1'b1;
        #1;
        chk("rel_c_ready", 64'(c_ready), 64'd1);
        chk("rel_bus_valid", 64'(bus_valid), 64'd0);
    endtask

    initial begin
        logic [4:0]  s_op[4];
        logic [63:0] s_c[4];
        int          acc_at[4];
        int          idx;
        int          n;
        logic        a;
        logic [4:0]  rop;
        logic [63:0] rc;

        // Power-on reset
        #3;
        chk("por_c_ready", 64'(c_ready), 64'd0);
        chk("por_bus_valid", 64'(bus_valid), 64'd0);
        chk("por_count", 64'(result_count), 64'd0);
        @(negedge clock);
        clear = 1'b1;
        #1;
        chk("por_rel_c_ready", 64'(c_ready), 64'd1);

        // add, single beat
        cyc(1'b1, OP_ADD, 64'hFFFFFFFF_FFFFFFFE, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("add_lo_data", 64'(bus_data), 64'hFFFFFFFE);
        chk("add_lo_hi", 64'(bus_hi), 64'd0);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("add_ext_err", 64'(ext_err), 64'd0);
        chk("add_count", 64'(result_count), 64'd1);
        chk("add_hi_reg", 64'(hi_reg), 64'd0);

        // mul with three stalled beats
        cyc(1'b1, OP_MUL, 64'h00000002_80000000, 1'b0);
        cyc(1'b0, OP_NOP, 64'd0, 1'b0);
        chk("mul_hi_reg", 64'(hi_reg), 64'h2);
        chk("mul_lo_reg", 64'(lo_reg), 64'h80000000);
        cyc(1'b0, OP_NOP, 64'd0, 1'b0);
        cyc(1'b0, OP_NOP, 64'd0, 1'b0);
        chk("mul_stall_data", 64'(bus_data), 64'h80000000);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("mul_hi_data", 64'(bus_data), 64'h2);
        chk("mul_hi_flag", 64'(bus_hi), 64'd1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);

        // sub sign-extension error is sticky
        cyc(1'b1, OP_SUB, 64'h00000000_80000000, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("sub_ext_set", 64'(ext_err), 64'd1);
        cyc(1'b1, OP_ADD, 64'h5, 1'b1);
        cyc(1'b1, OP_DIV, 64'h1_00000001, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("sub_ext_sticky", 64'(ext_err), 64'd1);

        // Stream with c_valid held
        do_reset();
        s_op[0] = OP_NOP; s_c[0] = 64'd0;
        s_op[1] = OP_NOP; s_c[1] = 64'd0;
        s_op[2] = OP_DIV; s_c[2] = 64'h00000003_00000007;
        s_op[3] = OP_ADD; s_c[3] = 64'h5;
        idx = 0;
        n = 0;
        while (idx < 4 && n < 20) begin
            cycle(1'b1, s_op[idx], s_c[idx], 1'b1, a);
            if (a) begin
                acc_at[idx] = n;
                idx++;
            end
            n++;
        end
        chk("stream_all_accepted", 64'(idx), 64'd4);
        chk("stream_nop_b2b", 64'(acc_at[1] - acc_at[0]), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("stream_count", 64'(result_count), 64'd4);

        // Counter wrap, then a result offered while not ready
        do_reset();
        for (int i = 0; i < 256; i++) cyc(1'b1, OP_NOP, 64'd0, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("wrap_count", 64'(result_count), 64'd0);
        cyc(1'b1, OP_ADD, 64'h9, 1'b0);
        cyc(1'b1, OP_NOP, 64'd0, 1'b0);
        cyc(1'b1, OP_ADD, 64'h3, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("notready_count", 64'(result_count), 64'd1);

        // Reset during the high beat
        cyc(1'b1, OP_MUL, 64'h00001234_00000001, 1'b1);
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);
        chk("pre_rst_hi_reg", 64'(hi_reg), 64'h1234);
        do_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: rop = OP_ADD;
                1: rop = OP_SUB;
                2: rop = OP_MUL;
                3: rop = OP_DIV;
                4: rop = OP_NOP;
                default: rop = 5'($urandom_range(0, 31));
            endcase
            rc = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rc[63:32] = {32{rc[31]}};
            cyc(1'($urandom_range(0, 1)), rop, rc, 1'($urandom_range(0, 3) != 0));
        end
        cyc(1'b0, OP_NOP, 64'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
